// File: rtl/data_sram_responder.sv
// Data-SRAM responder: byte-enabled word writes, full-word reads, and in-order
// responses a fixed RESP_DELAY cycles after each accepted request.
module data_sram_responder #(
    parameter int ADDR_WIDTH      = 12,
    parameter int RESP_DELAY      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_word;
    logic                  accept;
    logic [CW-1:0]         outstanding;
    logic [RESP_DELAY-1:0] pipe_valid;
    logic [31:0]           pipe_data [RESP_DELAY];

    // Size and the address bits outside the word index carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign idx     = addr[ADDR_WIDTH+1:2];
    assign rd_word = mem[idx];

    // A retiring response frees its slot in the same cycle, so a full
    // responder can still accept while data_ok is high.
    assign addr_ok = !reset && ((outstanding < MAX_CNT) || data_ok);
    assign accept  = req && addr_ok;

    assign data_ok = pipe_valid[RESP_DELAY-1];
    assign rdata   = pipe_data[RESP_DELAY-1];

    // Array has no reset so stores survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Slot data is forced to zero for stores and empty slots, which keeps
    // rdata at zero whenever data_ok is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid <= '0;
            for (int k = 0; k < RESP_DELAY; k++) begin
                pipe_data[k] <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_data[0]  <= (accept && !wr) ? rd_word : 32'h0;
            for (int k = 1; k < RESP_DELAY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({accept, data_ok})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a default instance and a MAX_OUTSTANDING=1,
// ADDR_WIDTH=10 instance, both checked every cycle against a queue-based model.
module tb_data_sram_responder;

    localparam int DLY  [2] = '{2, 2};
    localparam int MAXO [2] = '{2, 1};
    localparam int AW   [2] = '{12, 10};

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req, wr, aok, dok;
    logic [1:0]  size [2];
    logic [31:0] addr [2];
    logic [3:0]  wstrb [2];
    logic [31:0] wdata [2];
    logic [31:0] rd [2];

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    resp_t       q [2][$];
    logic [31:0] mem_m [int];
    logic [1:0]  acc;
    int          obs_acc [2];
    int          obs_dok [2];
    logic [31:0] last_rdata [2];

    data_sram_responder #(.ADDR_WIDTH(12), .RESP_DELAY(2), .MAX_OUTSTANDING(2)) dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]),
        .addr(addr[0]), .wstrb(wstrb[0]), .wdata(wdata[0]),
        .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0])
    );

    data_sram_responder #(.ADDR_WIDTH(10), .RESP_DELAY(2), .MAX_OUTSTANDING(1)) dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]),
        .addr(addr[1]), .wstrb(wstrb[1]), .wdata(wdata[1]),
        .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, cyc, got, exp);
        end
    endtask

    // Compare one cycle of outputs, then advance the model past the coming edge.
    task automatic check_and_update();
        for (int d = 0; d < 2; d++) begin
            logic        exp_dok, exp_aok;
            logic [31:0] exp_rd, word;
            int          key;
            resp_t       e;
            exp_dok = (q[d].size() > 0) && (q[d][0].due == cyc);
            exp_rd  = exp_dok ? q[d][0].data : 32'h0;
            exp_aok = !reset && ((q[d].size() < MAXO[d]) || exp_dok);
            chk("addr_ok", d, 32'(aok[d]), 32'(exp_aok));
            chk("data_ok", d, 32'(dok[d]), 32'(exp_dok));
            chk("rdata", d, rd[d], exp_rd);
            if (req[d] && aok[d]) obs_acc[d]++;
            if (dok[d]) begin
                obs_dok[d]++;
                last_rdata[d] = rd[d];
            end
            acc[d] = req[d] && exp_aok;
            if (reset) begin
                q[d].delete();
            end else begin
                if (exp_dok) void'(q[d].pop_front());
                if (acc[d]) begin
                    key  = d * 65536 + int'((addr[d] >> 2) & ((32'd1 << AW[d]) - 1));
                    word = mem_m.exists(key) ? mem_m[key] : 32'hx;
                    e.due  = cyc + DLY[d];
                    e.data = wr[d] ? 32'h0 : word;
                    q[d].push_back(e);
                    if (wr[d]) begin
                        for (int i = 0; i < 4; i++)
                            if (wstrb[d][i]) word[8*i +: 8] = wdata[d][8*i +: 8];
                        mem_m[key] = word;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_and_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] dat);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wstrb[d] = s; wdata[d] = dat;
        for (int n = 0; n < 20; n++) begin
            step();
            if (acc[d]) break;
        end
        chk("xfer_accepted", d, 32'(acc[d]), 32'd1);
        req[d] = 1'b0;
    endtask

    initial begin
        int a0, d0;
        reset = 1'b1;
        req = '0; wr = '0; acc = '0;
        for (int d = 0; d < 2; d++) begin
            size[d] = 2'd2; addr[d] = '0; wstrb[d] = '0; wdata[d] = '0;
            obs_acc[d] = 0; obs_dok[d] = 0; last_rdata[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        step();                         // reset state
        reset = 1'b0;
        step();                         // addr_ok up first cycle after reset

        // Store then load, default instance
        xfer(0, 1'b1, 32'h100, 4'hF, 32'h11223344);
        idle(2);
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0);
        idle(3);
        chk("load_full_word", 0, last_rdata[0], 32'h11223344);

        // Single byte lane store, then zero-strobe store
        xfer(0, 1'b1, 32'h101, 4'h2, 32'h0000AB00);
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0);
        idle(3);
        chk("byte_store", 0, last_rdata[0], 32'h1122AB44);
        d0 = obs_dok[0];
        xfer(0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF);
        idle(3);
        chk("nostrobe_resp", 0, 32'(obs_dok[0] - d0), 32'd1);
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0);
        idle(3);
        chk("nostrobe_keep", 0, last_rdata[0], 32'h1122AB44);

        // MAX_OUTSTANDING=1: held request accepted every other cycle
        xfer(1, 1'b1, 32'h100, 4'hF, 32'h55667788);
        idle(3);
        a0 = obs_acc[1]; d0 = obs_dok[1];
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h100;
        idle(5);
        req[1] = 1'b0;
        idle(3);
        chk("held_accepts", 1, 32'(obs_acc[1] - a0), 32'd3);
        chk("held_responses", 1, 32'(obs_dok[1] - d0), 32'd3);
        chk("held_rdata", 1, last_rdata[1], 32'h55667788);

        // Back-to-back loads at full throughput
        a0 = obs_acc[0]; d0 = obs_dok[0];
        req[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h100;
        idle(6);
        req[0] = 1'b0;
        idle(3);
        chk("stream_accepts", 0, 32'(obs_acc[0] - a0), 32'd6);
        chk("stream_responses", 0, 32'(obs_dok[0] - d0), 32'd6);

        // Reset while a load is in flight
        d0 = obs_dok[0];
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(3);
        chk("reset_drops_resp", 0, 32'(obs_dok[0] - d0), 32'd0);
        xfer(0, 1'b0, 32'h100, 4'h0, 32'h0);
        idle(3);
        chk("reset_keeps_mem", 0, last_rdata[0], 32'h1122AB44);

        // Upper address bits alias on the 10-bit instance
        xfer(1, 1'b1, 32'h1000, 4'hF, 32'hDEADBEEF);
        xfer(1, 1'b0, 32'h0000, 4'h0, 32'h0);
        idle(3);
        chk("alias", 1, last_rdata[1], 32'hDEADBEEF);

        // Store followed next cycle by load of the same word
        xfer(0, 1'b1, 32'h200, 4'hF, 32'hCAFEF00D);
        xfer(0, 1'b0, 32'h200, 4'h0, 32'h0);
        idle(3);
        chk("store_then_load", 0, last_rdata[0], 32'hCAFEF00D);

        // Random traffic over a small preloaded window
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++)
                xfer(d, 1'b1, 32'h300 + 32'(4 * k), 4'hF, $urandom);
        idle(3);
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!req[d] && $urandom_range(0, 2) != 0) begin
                    req[d]   = 1'b1;
                    wr[d]    = 1'($urandom_range(0, 1));
                    addr[d]  = (32'h300 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)))
                               | ($urandom & 32'hFFFF_C000);
                    size[d]  = 2'($urandom_range(0, 2));
                    wstrb[d] = 4'($urandom);
                    wdata[d] = $urandom;
                end
            end
            step();
            for (int d = 0; d < 2; d++)
                if (acc[d]) req[d] = 1'b0;
        end
        req = '0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder (slave) end of the CPU data-SRAM request/response interface: accepts load/store requests from the pipeline (issued in EXE, consumed in MEM), performs byte-enabled word writes and full-word reads on an internal word array, and returns in-order responses a fixed number of cycles after acceptance. Byte/halfword selection and sign extension of load data stay in the CPU's MEM stage; this block always returns the full aligned word. Used as the simulation/FPGA data memory behind the pipeline and as the timing reference for the CPU's wait-state handling.

## Interface

- ADDR_WIDTH, 12, word-index bits; depth = 2^ADDR_WIDTH 32-bit words
- RESP_DELAY, 2, cycles from accept cycle to data_ok cycle; legal range 1..8
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..RESP_DELAY

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  1  request valid
- wr  in  1  1 = store, 0 = load
- size  in  2  0 byte, 1 half, 2 word; informational only, not used for lane selection
- addr  in  32  byte address; word index = addr[ADDR_WIDTH+1:2], other bits ignored
- wstrb  in  4  byte-lane write enables, authoritative for stores
- wdata  in  32  store data, lanes already aligned by the CPU
- addr_ok  out  1  request accepted this cycle when req && addr_ok
- data_ok  out  1  one-cycle response pulse; master must always accept
- rdata  out  32  load data, valid only when data_ok

## Operation

- Accept: req && addr_ok on a rising edge; at most one accept per cycle.
- addr_ok = !reset && ((outstanding < MAX_OUTSTANDING) || data_ok); independent of req.
- Store: on accept edge, each byte lane i with wstrb[i]=1 takes wdata[8i+7:8i]; other lanes unchanged. wstrb=0 is a legal no-op store that still gets a response.
- Load: word sampled from array at accept edge (after any same-edge write from a previous cycle), so loads observe all earlier-accepted stores in order.
- Response pipe: RESP_DELAY-slot shift register of {valid, data}; accepted request enters slot 0, shifts one slot per cycle; data_ok/rdata driven from final slot (registered).
- rdata = loaded word for loads, 32'h0 for stores; 32'h0 whenever data_ok=0.
- Outstanding counter: +1 on accept, −1 on data_ok, unchanged when both; never exceeds MAX_OUTSTANDING.
- Responses strictly in acceptance order; no reordering, no error response.
- Upper address bits alias: addr 0x1000 and 0x0000 hit the same word when ADDR_WIDTH=10.
- Array contents not cleared by reset.

## Timing

- Reset: addr_ok=0, data_ok=0, rdata=0, outstanding=0, all pipe slots invalid. addr_ok=1 in the first cycle after reset deasserts.
- Accept in cycle t -> data_ok=1 exactly in cycle t+RESP_DELAY, for one cycle.
- Peak throughput: one request per cycle when MAX_OUTSTANDING=RESP_DELAY; otherwise limited to MAX_OUTSTANDING per RESP_DELAY cycles.
- Full (outstanding=MAX_OUTSTANDING): addr_ok=0 unless data_ok=1 that cycle, in which case accept and retire coincide.
- Reset mid-operation: pending responses discarded, never answered; stores already accepted remain in the array.
- Store followed next cycle by load to same word: load returns the new data.
- req held with addr_ok=0: no state change; master holds request fields stable.

## Test plan

- Defaults: store addr 0x100, wdata 0x11223344, wstrb 0xF accepted at t0 -> data_ok at t2 with rdata 0; load 0x100 accepted t3 -> data_ok t5, rdata 0x11223344.
- Byte store 0x101, wstrb 0x2, wdata 0x0000AB00, then load 0x100 -> rdata 0x1122AB44; wstrb 0x0 store -> data_ok pulses, word unchanged.
- MAX_OUTSTANDING=1, RESP_DELAY=2, req held for three loads from t0 -> accepts at t0, t2, t4; addr_ok low at t1, t3; data_ok at t2, t4, t6; responses in order.
- Defaults, loads every cycle t0..t5 -> accept every cycle, data_ok continuous t2..t7, outstanding never > 2.
- Load accepted t0, reset high t1 -> no data_ok at t2; addr_ok=0 during reset, 1 cycle after; prior stored data intact.
- ADDR_WIDTH=10: store 0x1000 value 0xDEADBEEF, load 0x0000 -> 0xDEADBEEF; store at t0 and load same word at t1 -> load sees new value at t3.
